// File: rtl/regfile_io.sv
// Register file with read ports, a debug read port and a GPIO register at the top index.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to r_data_1/r_data_2.
module regfile_io #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int IO_W   = 8,
   parameter int SYNC_N = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   r_sel_1,
   input  logic [AW-1:0]   r_sel_2,
   output logic [XLEN-1:0] r_data_1,
   output logic [XLEN-1:0] r_data_2,
   input  logic            w_en,
   input  logic [AW-1:0]   w_sel,
   input  logic [XLEN-1:0] w_data,
   input  logic [AW-1:0]   dbg_reg_sel,
   output logic [XLEN-1:0] dbg_reg_data,
   input  logic [IO_W-1:0] io_in,
   output logic [IO_W-1:0] io_out,
   output logic            io_irq
);

   localparam int            NREG    = 2**AW;
   localparam logic [AW-1:0] R_IO    = AW'(NREG-1);
   localparam int            IN_LO   = IO_W;
   localparam int            EDGE_LO = 2*IO_W;
   localparam int            HI_LO   = 3*IO_W;

   // Bits written directly by software on an R_IO write: OUT plus the spare upper storage.
   // A shift by XLEN yields zero, so the upper term vanishes when the fields fill the word.
   localparam logic [XLEN-1:0] RW_MASK =
      ~((XLEN'(1) << HI_LO) - XLEN'(1)) | ((XLEN'(1) << IO_W) - XLEN'(1));

   if (3*IO_W > XLEN) begin : g_bad_io_w
      $error("regfile_io: 3*IO_W must not exceed XLEN");
   end
   if (SYNC_N < 2) begin : g_bad_sync_n
      $error("regfile_io: SYNC_N must be at least 2");
   end

   logic [XLEN-1:0] gpr_q [NREG];
   logic [XLEN-1:0] io_q, io_d;
   logic [IO_W-1:0] sync_q [SYNC_N];
   logic [IO_W-1:0] io_out_q;

   logic            gpr_we, io_we;
   logic [IO_W-1:0] in_new, in_cur, edge_cur, edge_set, edge_clr, edge_nxt;

   assign gpr_we = w_en && (w_sel != '0) && (w_sel != R_IO);
   assign io_we  = w_en && (w_sel == R_IO);

   function automatic logic [XLEN-1:0] rd_stored(input logic [AW-1:0] sel);
      logic [XLEN-1:0] v;
      if (sel == '0)
         v = '0;
      else if (sel == R_IO)
         v = io_q;
      else
         v = gpr_q[sel];
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      end else if (gpr_we) begin
         gpr_q[w_sel] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= io_in;
         for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // A new rising edge on IN beats a simultaneous write-1-to-clear of the same flag.
   always_comb begin
      in_new   = sync_q[SYNC_N-1];
      in_cur   = io_q[IN_LO +: IO_W];
      edge_cur = io_q[EDGE_LO +: IO_W];
      edge_set = in_new & ~in_cur;
      edge_clr = io_we ? w_data[EDGE_LO +: IO_W] : '0;
      edge_nxt = (edge_cur & ~edge_clr) | edge_set;

      io_d = io_we ? ((io_q & ~RW_MASK) | (w_data & RW_MASK)) : io_q;
      io_d[IN_LO +: IO_W]   = in_new;
      io_d[EDGE_LO +: IO_W] = edge_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_q     <= '0;
         io_out_q <= '0;
      end else begin
         io_q     <= io_d;
         io_out_q <= io_q[IO_W-1:0];
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Only general registers forward; R_IO and the debug port always show stored state.
   assign r_data_1 = (gpr_we && (r_sel_1 == w_sel)) ? w_data : rd_stored(r_sel_1);
   assign r_data_2 = (gpr_we && (r_sel_2 == w_sel)) ? w_data : rd_stored(r_sel_2);
`else
   assign r_data_1 = rd_stored(r_sel_1);
   assign r_data_2 = rd_stored(r_sel_2);
`endif

   assign dbg_reg_data = rd_stored(dbg_reg_sel);
   assign io_out       = io_out_q;
   assign io_irq       = |io_q[EDGE_LO +: IO_W];

endmodule

// File: tb/tb_regfile_io.sv
// Self-checking bench for regfile_io; expectations are queued as stimulus is applied
// and popped against DUT outputs. Builds with or without REGFILE_BYPASS_EN.
module tb_regfile_io;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int IO_W = 8;
   localparam int SYNC_N = 2;
   localparam logic [AW-1:0] R_IO = 5'd31;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk, rst_n;
   logic [AW-1:0]   r_sel_1, r_sel_2, w_sel, dbg_reg_sel;
   logic [XLEN-1:0] r_data_1, r_data_2, w_data, dbg_reg_data;
   logic            w_en;
   logic [IO_W-1:0] io_in, io_out;
   logic            io_irq;

   regfile_io #(.XLEN(XLEN), .AW(AW), .IO_W(IO_W), .SYNC_N(SYNC_N)) dut (
      .clk(clk), .rst_n(rst_n),
      .r_sel_1(r_sel_1), .r_sel_2(r_sel_2),
      .r_data_1(r_data_1), .r_data_2(r_data_2),
      .w_en(w_en), .w_sel(w_sel), .w_data(w_data),
      .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
      .io_in(io_in), .io_out(io_out), .io_irq(io_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model [32];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_underflow: got %h expected <queued entry>", obs);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] sel, input logic [31:0] d);
      w_en = 1'b1; w_sel = sel; w_data = d;
      tick();
      w_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; w_en = 1'b0; w_sel = '0; w_data = '0;
      r_sel_1 = '0; r_sel_2 = '0; dbg_reg_sel = '0; io_in = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      repeat (3) tick();

      // reset state
      r_sel_1 = R_IO; r_sel_2 = 5; dbg_reg_sel = R_IO;
      sb_push("rst_rd1", 0); sb_push("rst_rd2", 0); sb_push("rst_dbg", 0);
      sb_push("rst_io_out", 0); sb_push("rst_irq", 0);
      #1;
      sb_pop(r_data_1); sb_pop(r_data_2); sb_pop(dbg_reg_data);
      sb_pop(32'(io_out)); sb_pop(32'(io_irq));

      // first write accepted on first edge after reset release
      w_en = 1'b1; w_sel = 3; w_data = 32'hA5A5_0001;
      rst_n = 1'b1;
      tick();
      w_en = 1'b0;
      model[3] = 32'hA5A5_0001;
      r_sel_1 = 3;
      sb_push("first_write", model[3]);
      #1 sb_pop(r_data_1);

      // x0 stays zero
      wr(0, 32'hDEAD_BEEF);
      r_sel_1 = 0; dbg_reg_sel = 0;
      sb_push("x0_rd1", 0); sb_push("x0_dbg", 0);
      #1 sb_pop(r_data_1); sb_pop(dbg_reg_data);

      // same-cycle read during write
      r_sel_2 = 5; dbg_reg_sel = 5;
      w_en = 1'b1; w_sel = 5; w_data = 32'h1234_5678;
      sb_push("x5_same_cycle", BYP ? 32'h1234_5678 : 32'h0);
      sb_push("x5_dbg_same_cycle", 0);
      #1 sb_pop(r_data_2); sb_pop(dbg_reg_data);
      tick();
      w_en = 1'b0;
      model[5] = 32'h1234_5678;
      sb_push("x5_next_cycle", 32'h1234_5678);
      sb_push("x5_dbg_next_cycle", 32'h1234_5678);
      #1 sb_pop(r_data_2); sb_pop(dbg_reg_data);

      // random fill of general registers, then read back on all ports
      for (int i = 1; i < 31; i++) begin
         model[i] = $urandom;
         wr(5'(i), model[i]);
      end
      for (int i = 1; i < 31; i++) begin
         r_sel_1 = 5'(i); r_sel_2 = 5'(31 - i); dbg_reg_sel = 5'(i);
         sb_push("fill_rd1", model[i]);
         sb_push("fill_rd2", model[31 - i]);
         sb_push("fill_dbg", model[i]);
         #1 sb_pop(r_data_1); sb_pop(r_data_2); sb_pop(dbg_reg_data);
      end

      // w_en=0 changes nothing
      w_en = 1'b0; w_sel = 6; w_data = ~model[6];
      tick();
      r_sel_1 = 6;
      sb_push("no_wen", model[6]);
      #1 sb_pop(r_data_1);

      // R_IO write: OUT and upper storage written, IN/EDGE untouched, never bypassed
      r_sel_1 = R_IO;
      w_en = 1'b1; w_sel = R_IO; w_data = 32'h5A00_FFA5;
      sb_push("rio_no_bypass", 0);
      #1 sb_pop(r_data_1);
      tick();
      w_en = 1'b0;
      sb_push("rio_after_write", 32'h5A00_00A5);
      sb_push("io_out_same_edge", 0);
      #1 sb_pop(r_data_1); sb_pop(32'(io_out));
      tick();
      sb_push("io_out_one_edge_later", 32'hA5);
      sb_pop(32'(io_out));

      // rising inputs reach IN after SYNC_N+1 edges and set EDGE
      io_in = 8'h81;
      repeat (SYNC_N) tick();
      sb_push("in_not_yet", 32'h5A00_00A5);
      sb_push("irq_not_yet", 0);
      sb_pop(r_data_1); sb_pop(32'(io_irq));
      tick();
      sb_push("in_edge_set", 32'h5A81_81A5);
      sb_push("irq_set", 1);
      sb_pop(r_data_1); sb_pop(32'(io_irq));

      // W1C of bit 0 only
      wr(R_IO, 32'h5A01_00A5);
      sb_push("w1c_bit0", 32'h5A80_81A5);
      sb_push("irq_bit7_left", 1);
      #1 sb_pop(r_data_1); sb_pop(32'(io_irq));
      wr(R_IO, 32'h5A80_00A5);
      sb_push("w1c_bit7", 32'h5A00_81A5);
      sb_push("irq_clear", 0);
      #1 sb_pop(r_data_1); sb_pop(32'(io_irq));

      // set and clear of bit 1 in the same cycle: set wins
      io_in = 8'h83;
      repeat (SYNC_N) tick();
      sb_push("irq_before_coincide", 0);
      sb_pop(32'(io_irq));
      wr(R_IO, 32'h5A02_00A5);
      sb_push("coincide_set_wins", 32'h5A02_83A5);
      sb_push("irq_coincide", 1);
      #1 sb_pop(r_data_1); sb_pop(32'(io_irq));
      wr(R_IO, 32'h5A02_00A5);
      sb_push("irq_bit1_cleared", 0);
      #1 sb_pop(32'(io_irq));

      // falling inputs never set EDGE
      io_in = 8'h00;
      repeat (SYNC_N + 1) tick();
      sb_push("fall_no_edge", 32'h5A00_00A5);
      sb_pop(r_data_1);

      // arm a pending flag and load x7 before the asynchronous reset
      io_in = 8'h04;
      repeat (SYNC_N + 1) tick();
      wr(7, 32'hFFFF_FFFF);
      r_sel_1 = 7; r_sel_2 = R_IO; dbg_reg_sel = 7;
      sb_push("x7_loaded", 32'hFFFF_FFFF);
      sb_push("irq_pending", 1);
      sb_push("io_out_pre_reset", 32'hA5);
      #1 sb_pop(r_data_1); sb_pop(32'(io_irq)); sb_pop(32'(io_out));

      // mid-cycle reset with a write held across edges
      #2;
      rst_n = 1'b0;
      w_en = 1'b1; w_sel = 9; w_data = 32'hCAFE_F00D;
      sb_push("rst_x7", 0); sb_push("rst_rio", 0); sb_push("rst_dbg_x7", 0);
      sb_push("rst_io_out_async", 0); sb_push("rst_irq_async", 0);
      #1;
      sb_pop(r_data_1); sb_pop(r_data_2); sb_pop(dbg_reg_data);
      sb_pop(32'(io_out)); sb_pop(32'(io_irq));
      tick();
      tick();
      w_en = 1'b0; io_in = 8'h00;
      rst_n = 1'b1;
      tick();
      r_sel_1 = 9;
      sb_push("write_in_reset_dropped", 0);
      #1 sb_pop(r_data_1);

      check_val("sb_leftover", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test expected $finish");
      $fatal(1);
   end

endmodule

// File: doc/regfile_io.md
REGFILE_IO -- requirements
Module: regfile_io

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, register width in bits.
- AW, 5, register index width; NREG = 2**AW registers.
- IO_W, 8, GPIO width; 3*IO_W <= XLEN is required.
- SYNC_N, 2, io_in synchroniser depth; SYNC_N >= 2 is required.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- r_sel_1 / r_sel_2, in, AW, read port indices.
- r_data_1 / r_data_2, out, XLEN, read port data.
- w_en, in, 1, write enable.
- w_sel, in, AW, write index.
- w_data, in, XLEN, write data.
- dbg_reg_sel, in, AW, debug read index.
- dbg_reg_data, out, XLEN, debug read data.
- io_in, in, IO_W, asynchronous GPIO inputs.
- io_out, out, IO_W, registered GPIO outputs.
- io_irq, out, 1, OR of all pending edge flags.

REQ-003 The block SHALL have one clock and an asynchronous, active-low reset (clk, rst_n).

Function
REQ-004 Register 0 SHALL read as zero on every read port; writes to index 0 SHALL be ignored.
REQ-005 Reads SHALL be combinational from the current register contents; dbg_reg_data SHALL behave as a third read port.
REQ-006 A write with w_en=1 and w_sel!=0 SHALL update register w_sel at the clock edge; a read of that index SHALL see the new value from the following cycle.
REQ-007 Index R_IO = NREG-1 SHALL be the IO register, laid out as follows:
- OUT = [IO_W-1:0], read/write.
- IN = [2*IO_W-1:IO_W], read-only.
- EDGE = [3*IO_W-1:2*IO_W], write-1-to-clear.
- Bits [XLEN-1:3*IO_W] are plain read/write storage.
REQ-008 io_in SHALL pass through a SYNC_N-stage flop chain; the IN field SHALL load the last chain stage every cycle, so a stable input change appears in IN SYNC_N+1 edges later.
REQ-009 Writes to R_IO SHALL leave the IN field unchanged.
REQ-010 EDGE bit i SHALL be set in the cycle IN[i] loads 1 while currently 0.
REQ-011 A write to R_IO with w_data EDGE bit i = 1 SHALL clear EDGE[i]; a w_data EDGE bit of 0 SHALL leave that flag unchanged.
REQ-012 If a set and a clear of the same EDGE bit coincide, the set SHALL win.
REQ-013 io_out SHALL be a register loading the OUT field every cycle, changing one edge after OUT changes.
REQ-014 io_irq SHALL equal the OR-reduction of the EDGE field, combinational from register state.
REQ-015 No state SHALL change when w_en=0, except the synchroniser chain, IN, EDGE set, and io_out.

Reset
REQ-016 While rst_n=0, every register, the synchroniser chain, and io_out SHALL be 0 asynchronously; consequently r_data_*, dbg_reg_data and io_irq SHALL read 0.
REQ-017 A write coinciding with an active reset SHALL be discarded.
REQ-018 After deassertion, the first write SHALL be accepted at the first rising clock edge.

Configuration
REQ-019 With macro REGFILE_BYPASS_EN defined, r_data_1 / r_data_2 SHALL return w_data combinationally when w_en=1, w_sel!=0, w_sel!=R_IO, and r_sel_n==w_sel.
REQ-020 dbg_reg_data and all R_IO reads SHALL never be bypassed.
REQ-021 Without REGFILE_BYPASS_EN, reads SHALL return only stored contents (old value during the write cycle).

Verification
REQ-022 Write x0=0xDEADBEEF, then read r_sel_1=0 -> r_data_1=0.
REQ-023 Write x5=0x12345678 with r_sel_2=5 in the same cycle:
- Same cycle -> 0x12345678 with REGFILE_BYPASS_EN, 0 without.
- Next cycle -> 0x12345678 in both builds.
REQ-024 Write R_IO w_data=0x000000A5 -> io_out=0xA5 exactly one edge later; the IN field is unaffected.
REQ-025 Drive io_in 0x00->0x81 and hold it:
- After SYNC_N+1 edges -> IN=0x81, EDGE=0x81, io_irq=1.
- Write EDGE=0x01 -> EDGE=0x80, io_irq=1.
REQ-026 Coincident edge set and W1C clear on the same bit -> the bit remains 1.
REQ-027 Assert rst_n=0 mid-cycle with x7=0xFFFFFFFF -> x7, io_out and io_irq read 0 immediately, without a clock edge.
